// File: rtl/edd_checkout_ctrl.sv
// edd_checkout_ctrl: self-checkout sequencer driving the electronic discount/theft detector.
// Define EDD_ALARM_LATCH_EN to latch a stolen result in ALARM until clear.
module edd_checkout_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_ITEMS = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan,
    input  logic       clear,
    input  logic [2:0] upc_in,
    input  logic       mark_in,
    output logic [2:0] edd_upc,
    output logic       edd_mark,
    input  logic       edd_discount,
    input  logic       edd_stolen,
    output logic       busy,
    output logic [3:0] item_count,
    output logic [3:0] disc_count,
    output logic       alarm,
    output logic       done
);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam logic [3:0] MAX_CNT = 4'(MAX_ITEMS);
`ifdef EDD_ALARM_LATCH_EN
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, ALARM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
`endif
    state_t state;
    logic [3:0] settle_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            settle_cnt <= '0;
            edd_upc <= '0;
            edd_mark <= 1'b0;
            item_count <= '0;
            disc_count <= '0;
            alarm <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            settle_cnt <= '0;
            edd_upc <= '0;
            edd_mark <= 1'b0;
            item_count <= '0;
            disc_count <= '0;
            alarm <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= 1'b0;
`ifndef EDD_ALARM_LATCH_EN
            alarm <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (scan && item_count < MAX_CNT) begin
                        edd_upc <= upc_in;
                        edd_mark <= mark_in;
                        settle_cnt <= SETTLE_LD;
                        state <= SETTLE;
                        busy <= 1'b1;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) state <= SAMPLE;
                end
                SAMPLE: begin
                    // disc_count only moves with item_count, so it can never overtake it
                    item_count <= (item_count < MAX_CNT) ? item_count + 4'd1 : item_count;
                    disc_count <= (edd_discount && disc_count < MAX_CNT) ? disc_count + 4'd1 : disc_count;
                    done <= 1'b1;
`ifdef EDD_ALARM_LATCH_EN
                    state <= edd_stolen ? ALARM : IDLE;
                    busy <= edd_stolen;
                    alarm <= edd_stolen;
`else
                    state <= IDLE;
                    busy <= 1'b0;
                    alarm <= edd_stolen;
`endif
                end
                default: begin
`ifndef EDD_ALARM_LATCH_EN
                    state <= IDLE;
                    busy <= 1'b0;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_edd_checkout_ctrl.sv
// tb_edd_checkout_ctrl: table-driven scans plus directed corner sequences for edd_checkout_ctrl.
module tb_edd_checkout_ctrl;
    localparam int S = 2;
    localparam int M = 9;
    logic clk = 1'b0, reset = 1'b1, scan = 1'b0, clear = 1'b0, mark_in = 1'b0;
    logic [2:0] upc_in = '0;
    logic edd_discount = 1'b0, edd_stolen = 1'b0;
    logic [2:0] edd_upc;
    logic edd_mark, busy, alarm, done;
    logic [3:0] item_count, disc_count;
    int tests = 0, fails = 0;

    edd_checkout_ctrl #(.SETTLE_CYCLES(S), .MAX_ITEMS(M)) dut (
        .clk(clk), .reset(reset), .scan(scan), .clear(clear), .upc_in(upc_in), .mark_in(mark_in),
        .edd_upc(edd_upc), .edd_mark(edd_mark), .edd_discount(edd_discount), .edd_stolen(edd_stolen),
        .busy(busy), .item_count(item_count), .disc_count(disc_count), .alarm(alarm), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] upc;
        logic mark, disc;
        logic [3:0] item, dc;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // caller is at a negedge; leaves at the negedge where done is seen (or timeout)
    task automatic do_scan(input logic [2:0] u, input logic m, input logic d, input logic s);
        int lat = 0;
        upc_in = u; mark_in = m; edd_discount = d; edd_stolen = s; scan = 1'b1;
        @(negedge clk);
        scan = 1'b0; upc_in = ~u; mark_in = ~m;
        chk("busy_after_accept", int'(busy), 1);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("done_latency", lat, S + 1);
        chk("edd_upc_held", int'(edd_upc), int'(u));
        chk("edd_mark_held", int'(edd_mark), int'(m));
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int n;
        vt[0] = '{3'b110, 1'b0, 1'b1, 4'd1, 4'd1};
        vt[1] = '{3'b101, 1'b1, 1'b0, 4'd2, 4'd1};
        vt[2] = '{3'b011, 1'b0, 1'b1, 4'd3, 4'd2};
        vt[3] = '{3'b111, 1'b1, 1'b1, 4'd4, 4'd3};

        repeat (2) @(negedge clk);
        chk("rst_item", int'(item_count), 0);
        chk("rst_disc", int'(disc_count), 0);
        chk("rst_outs", int'({edd_upc, edd_mark, busy, alarm, done}), 0);
        reset = 1'b0;

        // first scan rides the very first edge with reset low
        foreach (vt[i]) begin
            do_scan(vt[i].upc, vt[i].mark, vt[i].disc, 1'b0);
            chk($sformatf("v%0d_item", i), int'(item_count), int'(vt[i].item));
            chk($sformatf("v%0d_disc", i), int'(disc_count), int'(vt[i].dc));
            chk($sformatf("v%0d_alarm", i), int'(alarm), 0);
            @(negedge clk);
            chk($sformatf("v%0d_busy_idle", i), int'(busy), 0);
        end

        // saturation at MAX_ITEMS
        do_clear();
        chk("clr_item", int'(item_count), 0);
        chk("clr_disc", int'(disc_count), 0);
        for (int i = 0; i < M; i++) do_scan(3'b001, 1'b0, 1'b0, 1'b0);
        chk("sat_item", int'(item_count), M);
        chk("sat_disc", int'(disc_count), 0);
        @(negedge clk);
        scan = 1'b1;
        @(negedge clk);
        scan = 1'b0;
        chk("sat_busy", int'(busy), 0);
        count_done(S + 4, n);
        chk("sat_no_done", n, 0);
        chk("sat_item_hold", int'(item_count), M);

        // scan held through SETTLE with a changing code
        do_clear();
        edd_discount = 1'b0; edd_stolen = 1'b0;
        upc_in = 3'b010; mark_in = 1'b1; scan = 1'b1;
        @(negedge clk);
        upc_in = 3'b101; mark_in = 1'b0;
        repeat (2) @(negedge clk);
        scan = 1'b0;
        count_done(8, n);
        chk("rep_one_done", n, 1);
        chk("rep_upc", int'(edd_upc), 3'b010);
        chk("rep_mark", int'(edd_mark), 1);
        chk("rep_item", int'(item_count), 1);

        // stolen handling
        do_clear();
        do_scan(3'b100, 1'b1, 1'b0, 1'b1);
        chk("stolen_alarm_with_done", int'(alarm), 1);
        chk("stolen_item", int'(item_count), 1);
        @(negedge clk);
        edd_stolen = 1'b0;
`ifdef EDD_ALARM_LATCH_EN
        chk("alarm_latched", int'(alarm), 1);
        chk("alarm_busy", int'(busy), 1);
        scan = 1'b1;
        @(negedge clk);
        scan = 1'b0;
        count_done(S + 4, n);
        chk("alarm_scan_ignored", n, 0);
        chk("alarm_still", int'(alarm), 1);
`else
        chk("alarm_pulse_end", int'(alarm), 0);
        chk("alarm_busy", int'(busy), 0);
`endif
        do_clear();
        chk("alarm_cleared", int'(alarm), 0);
        chk("alarm_clr_counts", int'({item_count, disc_count}), 0);

        // reset mid-SETTLE discards the item
        upc_in = 3'b111; edd_discount = 1'b1; scan = 1'b1;
        @(negedge clk);
        scan = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_outs", int'({edd_upc, edd_mark, item_count, disc_count, alarm, done}), 0);
        @(negedge clk);
        reset = 1'b0;
        count_done(S + 4, n);
        chk("midrst_no_done", n, 0);

        // clear beats scan in the same IDLE cycle
        do_scan(3'b011, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        clear = 1'b1; scan = 1'b1; upc_in = 3'b110;
        @(negedge clk);
        clear = 1'b0; scan = 1'b0;
        chk("clrscan_busy", int'(busy), 0);
        chk("clrscan_outs", int'({edd_upc, edd_mark, item_count, disc_count, alarm, done}), 0);
        count_done(S + 4, n);
        chk("clrscan_no_done", n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
